// File: rtl/sar_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sar_pkg
// Description : Shared types and constants for the SAR control blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package sar_pkg;

    localparam int ADC_W           = 8;
    localparam int DEFAULT_TIMEOUT = 31;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_START    = 2'd1,
        ST_WAIT_EOC = 2'd2,
        ST_OUTPUT   = 2'd3
    } sar_state_t;

endpackage
`default_nettype wire

// File: rtl/sar_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : sar_watchdog
// Description : Cycle counter that flags when TIMEOUT ticks have elapsed.
// Revision    : 1.0 - initial release
// ============================================================================
module sar_watchdog #(
    parameter int TIMEOUT = 31
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    // One spare code above TIMEOUT so the counter never wraps while ticking.
    localparam int c_TCNT_W = $clog2(TIMEOUT + 2);

    logic [c_TCNT_W-1:0] r_tcnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_tcnt <= '0;
        end else if (tick) begin
            r_tcnt <= r_tcnt + c_TCNT_W'(1);
        end
    end

    assign expired = (r_tcnt == c_TCNT_W'(TIMEOUT));

endmodule
`default_nettype wire

// File: rtl/sar_avg_seq.sv
`default_nettype none
// ============================================================================
// Module      : sar_avg_seq
// Description : Sequences SAR conversions and averages batches of 2^LOG2N
//               results (round half up) behind a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module sar_avg_seq
    import sar_pkg::*;
#(
    parameter int LOG2N   = 2,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output logic             soc,
    input  logic             eoc,
    input  logic [ADC_W-1:0] d,
    output logic [ADC_W-1:0] avg_data,
    output logic             avg_valid,
    input  logic             avg_ready,
    output logic             timeout_err
);

    localparam int c_ACC_W = ADC_W + LOG2N;

    sar_state_t          r_state;
    sar_state_t          w_next;
    logic [c_ACC_W-1:0]  r_acc;
    logic [LOG2N-1:0]    r_cnt;
    logic [ADC_W-1:0]    r_avg;
    logic                r_terr;
    logic                w_soc;
    logic                w_valid;
    logic                w_expired;
    logic                w_last;
    logic [c_ACC_W-1:0]  w_sum;
    logic [c_ACC_W-1:0]  w_rounded;
    logic [ADC_W-1:0]    w_avg;

    assign w_last    = (r_cnt == {LOG2N{1'b1}});
    assign w_sum     = r_acc + c_ACC_W'(d);
    // N*255 + N/2 stays below 2^(ADC_W+LOG2N), so rounding cannot overflow.
    assign w_rounded = w_sum + (c_ACC_W'(1) << (LOG2N - 1));
    assign w_avg     = ADC_W'(w_rounded >> LOG2N);

    sar_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (r_state == ST_START),
        .tick    (r_state == ST_WAIT_EOC),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_soc   = 1'b1;
        w_valid = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_next = ST_START;
                end
            end
            ST_START: begin
                w_next = ST_WAIT_EOC;
            end
            ST_WAIT_EOC: begin
                w_soc = 1'b0;
                // A result arriving on the final allowed cycle beats the timeout.
                if (eoc) begin
                    w_next = w_last ? ST_OUTPUT : ST_START;
                end else if (w_expired) begin
                    w_next = ST_IDLE;
                end
            end
            ST_OUTPUT: begin
                w_valid = 1'b1;
                if (avg_ready) begin
                    w_next = enable ? ST_START : ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_avg  <= '0;
            r_terr <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                ST_WAIT_EOC: begin
                    if (eoc) begin
                        r_acc <= w_sum;
                        r_cnt <= r_cnt + LOG2N'(1);
                        if (w_last) begin
                            r_avg <= w_avg;
                        end
                    end else if (w_expired) begin
                        r_terr <= 1'b1;
                        r_acc  <= '0;
                        r_cnt  <= '0;
                    end
                end
                ST_OUTPUT: begin
                    if (avg_ready && enable) begin
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign soc         = w_soc;
    assign avg_valid   = w_valid;
    assign avg_data    = r_avg;
    assign timeout_err = r_terr;

endmodule
`default_nettype wire

// File: tb/tb_sar_avg_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_sar_avg_seq
// Description : Self-checking bench for sar_avg_seq with a behavioural SAR
//               stub and batch-average scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sar_avg_seq;

    localparam int LOG2N   = 2;
    localparam int N       = 1 << LOG2N;
    localparam int TIMEOUT = 31;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       eoc = 1'b0;
    logic [7:0] d = 8'd0;
    logic       avg_ready = 1'b0;
    logic       soc;
    logic [7:0] avg_data;
    logic       avg_valid;
    logic       timeout_err;

    sar_avg_seq #(
        .LOG2N   (LOG2N),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .soc         (soc),
        .eoc         (eoc),
        .d           (d),
        .avg_data    (avg_data),
        .avg_valid   (avg_valid),
        .avg_ready   (avg_ready),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Stub and scoreboard state.
    int lat_fix  = 3;
    bit lat_rand = 1'b0;
    bit hang     = 1'b0;
    int cur_lat  = 0;
    int widx     = 0;
    int stim_q[$];
    int part_q[$];
    int exp_q[$];
    bit m_terr   = 1'b0;
    bit armed    = 1'b0;
    int n_acc    = 0;

    function automatic int avg_of(input int q[$]);
        int sum;
        sum = 0;
        foreach (q[i]) sum += q[i];
        return (sum + N / 2) / N;
    endfunction

    // Outputs are checked at the falling edge, then the SAR stub decides what
    // eoc/d look like at the coming rising edge and the scoreboard follows.
    always @(negedge clk) begin
        int v;
        if (armed) begin
            chk("avg_valid", avg_valid, (exp_q.size() != 0) ? 1 : 0);
            if (avg_valid) begin
                chk("soc_in_output", soc, 1);
                if (exp_q.size() != 0) chk("avg_data", avg_data, exp_q[0]);
            end
            chk("timeout_err", timeout_err, m_terr);
        end
        if (rst) begin
            part_q.delete();
            exp_q.delete();
            m_terr = 1'b0;
            widx   = 0;
            eoc    = 1'b0;
            armed  = 1'b1;
        end else if (soc) begin
            widx    = 0;
            eoc     = 1'b0;
            cur_lat = hang ? 1000 : (lat_rand ? int'($urandom_range(0, TIMEOUT + 2)) : lat_fix);
            if (avg_valid && avg_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        end else begin
            if (widx == cur_lat) begin
                eoc = 1'b1;
                v   = (stim_q.size() != 0) ? stim_q.pop_front() : int'($urandom_range(0, 255));
                d   = 8'(v);
                part_q.push_back(v);
                n_acc++;
                if (part_q.size() == N) begin
                    exp_q.push_back(avg_of(part_q));
                    part_q.delete();
                end
            end else begin
                eoc = 1'b0;
                if (widx == TIMEOUT) begin
                    m_terr = 1'b1;
                    part_q.delete();
                end
            end
            widx++;
        end
        if (!eoc) d = 8'($urandom);
    end

    int soc_falls = 0;
    bit prev_soc  = 1'b1;
    always @(negedge clk) begin
        if (prev_soc && !soc) soc_falls++;
        prev_soc = soc;
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input string name, input int budget);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (avg_valid) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) chk({name, "_wait_valid"}, 0, 1);
    endtask

    task automatic start_one_batch();
        int f0;
        f0     = soc_falls;
        enable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (soc_falls != f0) break;
        end
        enable = 1'b0;
    endtask

    task automatic run_batch(input string name, input int v0, input int v1,
                             input int v2, input int v3, input int expv);
        stim_q.delete();
        stim_q.push_back(v0);
        stim_q.push_back(v1);
        stim_q.push_back(v2);
        stim_q.push_back(v3);
        avg_ready = 1'b1;
        start_one_batch();
        wait_valid(name, 600);
        chk(name, avg_data, expv);
        step(3);
    endtask

    initial begin
        int f0;
        int vc;
        int wc;
        int a0;
        int d0;

        step(2);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_soc", soc, 1);
        chk("rst_valid", avg_valid, 0);
        chk("rst_data", avg_data, 0);
        chk("rst_terr", timeout_err, 0);

        // Nominal batch.
        step();
        stim_q = '{10, 11, 12, 13};
        lat_fix   = 3;
        avg_ready = 1'b1;
        f0 = soc_falls;
        start_one_batch();
        wait_valid("nom", 600);
        chk("nom_avg", avg_data, 12);
        vc = 0;
        while (avg_valid && vc < 50) begin
            vc++;
            @(negedge clk);
        end
        chk("nom_valid_cycles", vc, 1);
        step(3);
        chk("nom_soc_pulses", soc_falls - f0, 4);

        run_batch("round", 1, 2, 2, 2, 2);
        run_batch("max", 255, 255, 255, 255, 255);

        // Backpressure.
        stim_q.delete();
        avg_ready = 1'b0;
        enable    = 1'b1;
        wait_valid("bp", 600);
        d0 = avg_data;
        f0 = soc_falls;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_valid", avg_valid, 1);
            chk("bp_data", avg_data, d0);
            chk("bp_soc", soc, 1);
        end
        chk("bp_no_conv", soc_falls, f0);
        step();
        avg_ready = 1'b1;
        @(negedge clk);
        chk("bp_last_valid", avg_valid, 1);
        @(negedge clk);
        chk("bp_start_valid", avg_valid, 0);
        chk("bp_start_soc", soc, 1);
        @(negedge clk);
        chk("bp_wait_soc", soc, 0);
        step();
        enable = 1'b0;
        wait_valid("bp_drain", 600);
        step(3);

        // Result on the very last accepted cycle.
        lat_fix = TIMEOUT;
        run_batch("tedge", 7, 8, 9, 10, 9);
        chk("tedge_terr", timeout_err, 0);
        lat_fix = 3;

        // Timeout with enable held: count WAIT cycles until the flag appears.
        hang      = 1'b1;
        avg_ready = 1'b1;
        enable    = 1'b1;
        wc = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (timeout_err) break;
            if (!soc) wc++;
        end
        chk("to_wait_cycles", wc, 32);
        chk("to_flag", timeout_err, 1);
        chk("to_idle_soc", soc, 1);
        hang = 1'b0;
        @(negedge clk);
        chk("to_restart_start", soc, 1);
        @(negedge clk);
        chk("to_restart_wait", soc, 0);
        wait_valid("to_recover", 600);
        chk("to_sticky", timeout_err, 1);
        enable = 1'b0;
        step(3);

        // Reset after two accepted conversions.
        stim_q.delete();
        enable = 1'b1;
        a0 = n_acc;
        for (int i = 0; i < 400; i++) begin
            step();
            if (n_acc - a0 >= 2) break;
        end
        chk("rst_mid_progress", (n_acc - a0 >= 2) ? 1 : 0, 1);
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("rstm_soc", soc, 1);
        chk("rstm_valid", avg_valid, 0);
        chk("rstm_terr", timeout_err, 0);
        step();
        enable = 1'b0;
        rst    = 1'b0;
        run_batch("rstm_avg", 100, 100, 100, 104, 101);

        // Randomised traffic.
        lat_rand = 1'b1;
        enable   = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            step();
            avg_ready = ($urandom_range(0, 3) != 0);
            enable    = ($urandom_range(0, 19) != 0);
        end
        lat_rand  = 1'b0;
        enable    = 1'b0;
        avg_ready = 1'b1;
        step(300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
